hbus_txn_seq: RTL
=================

# hbus_txn_seq

Transaction sequencer for the HyperBus link. It sits directly downstream of the address decoder: it accepts the 48-bit command-address (CA) word, bit 47 = R/W# (1 = read), and serializes it onto the 8-bit DQ bus. It then counts initial latency and runs a fixed-length write or read data phase. On completion it returns a single response to the requester. The bus is modelled as one byte per `clk` cycle; DDR conversion happens in the PHY below this block.

## Interface

Parameters:

- `LATENCY`, 6: initial latency in cycles; doubled when RWDS is high at CA start.
- `DATA_BYTES`, 4: bytes per burst, 1..32.
- `RD_TIMEOUT`, 64: maximum read data-phase cycles before abort, ≥ `DATA_BYTES`.

Ports:

- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_ca` in 48: CA word from the address decoder.
- `req_wdata` in 8*DATA_BYTES: write payload, MSB byte sent first.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: read timeout; valid with `rsp_valid`.
- `rsp_rdata` out 8*DATA_BYTES: read payload, first byte received in the MSB; held until the next accept.
- `hb_cs_n` out 1: chip select, active low.
- `hb_dq_o` out 8: DQ drive.
- `hb_dq_oe` out 1: DQ output enable.
- `hb_dq_i` in 8: DQ sample.
- `hb_rwds_o` out 1: write mask; always 0.
- `hb_rwds_oe` out 1: RWDS output enable.
- `hb_rwds_i` in 1: latency flag during CA; read strobe during the data phase.

## Operation

- **Reset values:** state IDLE; `req_ready`=1; `hb_cs_n`=1; `hb_dq_o`=0; `hb_dq_oe`=0; `hb_rwds_o`=0; `hb_rwds_oe`=0; `rsp_valid`=0; `rsp_err`=0; `rsp_rdata`=0.
- **Accept:** `req_valid && req_ready`. `req_ca` and `req_wdata` are registered on accept; later changes on those inputs are ignored.
- **IDLE → CA:** on accept.
- **CA:** 6 cycles. `hb_cs_n`=0 and `hb_dq_oe`=1. Byte k (k=0..5) drives `ca[47-8k -: 8]`. `hb_rwds_i` is sampled in the cycle of byte 0 into `dbl_lat`.
- **CA → LAT:** after byte 5.
- **LAT:** lasts `LATENCY` cycles, or 2*`LATENCY` when `dbl_lat`=1. `hb_dq_oe`=0 and `hb_cs_n`=0.
- **LAT → WDATA** when `ca[47]`=0; **LAT → RDATA** when `ca[47]`=1.
- **WDATA:** `DATA_BYTES` cycles. `hb_dq_oe`=1, `hb_rwds_oe`=1, `hb_rwds_o`=0. Bytes are driven MSB first.
- **RDATA:** `hb_dq_oe`=0. In each cycle with `hb_rwds_i`=1, `hb_dq_i` is shifted into the byte counter's next position.
    - After byte `DATA_BYTES`-1 is captured, go to DONE.
    - If `RD_TIMEOUT` cycles elapse in RDATA first, go to DONE with the error flag set. Partial data is discarded and `rsp_rdata` is zeroed.
- **DONE:** 1 cycle. `hb_cs_n`=1. `rsp_valid`=1, and `rsp_err` is set only on timeout. Next state is IDLE.
- **Back-to-back requests:** `req_ready` returns high the cycle after DONE, so CS# is always high for at least 2 cycles between transactions.
- **Reset mid-transaction:** at the next edge the block returns to IDLE with all outputs at their reset values. No `rsp_valid` is issued for the aborted transaction.
- **Counters:** saturate-free and sized with `$clog2` of their max count + 1. Byte index wraps never, since the state exits before overflow.

## Timing

Transaction accepted at edge T:

- CA bytes on cycles T+1..T+6.
- Latency on T+7..T+6+L, with L = `LATENCY` or 2*`LATENCY`.
- Write data on T+7+L..T+6+L+`DATA_BYTES`; `rsp_valid` at T+7+L+`DATA_BYTES`.
    - Defaults: T+17 at single latency, T+23 at double.
- Read `rsp_valid` follows one cycle after the cycle capturing the last strobed byte.
- Timeout: `rsp_valid` at T+7+L+`RD_TIMEOUT`.

## Structure

- Package `hbus_pkg` holds:
    - `hbus_state_e` (IDLE, CA, LAT, WDATA, RDATA, DONE)
    - `CA_BYTES`=6, `CA_RW_BIT`=47
    - `CA_W`=48
- One sub-module, `hbus_byte_shifter`. It is a parameterized load/shift-out and shift-in register of width 8*N, used for the CA (N=6), write, and read paths.
- The state machine and counters stay in `hbus_txn_seq`.

## Test plan

1. **Reset, then single-latency write.** Reset, then accept write CA=48'h0000_0001_0002, wdata=32'hDEADBEEF, `hb_rwds_i`=0.
    - DQ shows 00,00,00,01,00,02 on T+1..T+6.
    - DQ is idle (oe=0) for 6 cycles, then DE,AD,BE,EF with rwds_oe=1.
    - `rsp_valid`=1, err=0 at T+17.
2. **Double-latency read.** Read CA=48'h8000_0000_0004 with `hb_rwds_i`=1 at T+1.
    - 12 latency cycles.
    - Model strobes 11,22,33,44 with gaps of 1 idle cycle.
    - `rsp_rdata`=32'h11223344, `rsp_valid` pulse once.
3. **Read timeout.** Read with `hb_rwds_i` held 0 after CA.
    - `rsp_valid`=1 and `rsp_err`=1 at T+13+64.
    - `rsp_rdata`=0 and `hb_cs_n`=1 that cycle.
4. **Back-to-back requests.** `req_valid` held high with two writes.
    - Second accept is the cycle after the first DONE.
    - CS# is high exactly 2 cycles between transactions.
    - Input changes during busy are ignored.
5. **Reset mid-transaction.** Assert `rst` during LAT of a read.
    - Next cycle: `hb_cs_n`=1, `req_ready`=1, no `rsp_valid`.
    - A following write completes normally.

Source files
------------

// File: rtl/hbus_pkg.sv
// Shared types and constants for the HyperBus transaction sequencer.
package hbus_pkg;

    localparam int CA_BYTES  = 6;
    localparam int CA_RW_BIT = 47;
    localparam int CA_W      = 48;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        WDATA,
        RDATA,
        DONE
    } hbus_state_e;

    function automatic logic ca_is_read(input logic [CA_W-1:0] ca);
        return ca[CA_RW_BIT];
    endfunction

endpackage

// File: rtl/hbus_byte_shifter.sv
// Byte-wide load / shift register: parallel load, then shift left one byte per
// cycle, presenting the MSB byte first and taking new bytes in at the LSB.
module hbus_byte_shifter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [8*N-1:0] load_data,
    input  logic           shift,
    input  logic [7:0]     shift_in,
    output logic [8*N-1:0] q
);

    logic [8*N-1:0] shifted;

    generate
        if (N == 1) begin : g_one
            assign shifted = shift_in;
        end else begin : g_multi
            assign shifted = {q[8*N-9:0], shift_in};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= shifted;
        end
    end

endmodule

// File: rtl/hbus_txn_seq.sv
// HyperBus transaction sequencer: serializes the CA word, counts initial
// latency, runs a fixed-length write or read burst and returns one response.
module hbus_txn_seq
    import hbus_pkg::*;
#(
    parameter int LATENCY    = 6,
    parameter int DATA_BYTES = 4,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CA_W-1:0]         req_ca,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    hb_cs_n,
    output logic [7:0]              hb_dq_o,
    output logic                    hb_dq_oe,
    input  logic [7:0]              hb_dq_i,
    output logic                    hb_rwds_o,
    output logic                    hb_rwds_oe,
    input  logic                    hb_rwds_i
);

    localparam int DW      = 8*DATA_BYTES;
    localparam int MAX_A   = (2*LATENCY > CA_BYTES) ? 2*LATENCY : CA_BYTES;
    localparam int CNT_MAX = (MAX_A > DATA_BYTES) ? MAX_A : DATA_BYTES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(RD_TIMEOUT + 1);

    localparam logic [CW-1:0] CA_LAST   = CW'(CA_BYTES - 1);
    localparam logic [CW-1:0] LAT1_LAST = CW'(LATENCY - 1);
    localparam logic [CW-1:0] LAT2_LAST = CW'(2*LATENCY - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(RD_TIMEOUT - 1);

    hbus_state_e    state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [TW-1:0]  tmo_cnt;
    logic           dbl_lat;
    logic           is_rd;
    logic           err_q;
    logic [CA_W-1:0] ca_q;
    logic [DW-1:0]  data_q;
    logic [CW-1:0]  lat_last;
    logic           accept;
    logic           strobe;
    logic           rd_last;
    logic           tmo;
    logic           unused_ca;

    assign accept   = req_valid && (state == IDLE);
    assign strobe   = (state == RDATA) && hb_rwds_i;
    assign rd_last  = strobe && (cnt == DATA_LAST);
    // A byte landing on the final allowed cycle still counts as a good read.
    assign tmo      = (state == RDATA) && (tmo_cnt == TMO_LAST) && !rd_last;
    assign lat_last = dbl_lat ? LAT2_LAST : LAT1_LAST;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = CA;
            CA:      if (cnt == CA_LAST) state_nxt = LAT;
            LAT:     if (cnt == lat_last) state_nxt = is_rd ? RDATA : WDATA;
            WDATA:   if (cnt == DATA_LAST) state_nxt = DONE;
            RDATA:   if (rd_last || tmo) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tmo_cnt <= '0;
            dbl_lat <= 1'b0;
            is_rd   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if ((state inside {CA, LAT, WDATA}) || strobe) begin
                cnt <= cnt + CW'(1);
            end
            if (state == RDATA) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (state == CA && cnt == '0) begin
                dbl_lat <= hb_rwds_i;
            end
            if (accept) begin
                is_rd <= ca_is_read(req_ca);
                err_q <= 1'b0;
            end else if (tmo) begin
                err_q <= 1'b1;
            end
        end
    end

    hbus_byte_shifter #(.N(CA_BYTES)) u_ca_sh (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (req_ca),
        .shift     (state == CA),
        .shift_in  (8'h00),
        .q         (ca_q)
    );

    // One register serves both directions: write bytes leave from the top
    // while read bytes enter at the bottom, so after a full read burst it
    // holds the response payload. A timeout reloads it with zero.
    hbus_byte_shifter #(.N(DATA_BYTES)) u_data_sh (
        .clk       (clk),
        .rst       (rst),
        .load      (accept || tmo),
        .load_data (accept ? req_wdata : '0),
        .shift     ((state == WDATA) || strobe),
        .shift_in  ((state == RDATA) ? hb_dq_i : 8'h00),
        .q         (data_q)
    );

    assign unused_ca = ^ca_q[CA_W-9:0];

    always_comb begin
        req_ready  = (state == IDLE);
        hb_cs_n    = !(state inside {CA, LAT, WDATA, RDATA});
        hb_dq_oe   = (state == CA) || (state == WDATA);
        hb_dq_o    = 8'h00;
        hb_rwds_o  = 1'b0;
        hb_rwds_oe = (state == WDATA);
        rsp_valid  = (state == DONE);
        rsp_err    = (state == DONE) && err_q;
        rsp_rdata  = data_q;
        if (state == CA) begin
            hb_dq_o = ca_q[CA_W-1 -: 8];
        end else if (state == WDATA) begin
            hb_dq_o = data_q[DW-1 -: 8];
        end
    end

endmodule
